// File: rtl/ft_tx_arbiter.sv
// ft_tx_arbiter: packet arbiter feeding the FTDI read port from one CPU FIFO and N_IQ IQ FIFOs.
//   clk_i, reset_n               : FTDI clock, async active-low reset
//   iq_data_i/iq_enough_i/iq_mask_i : IQ FIFO read data, packet-ready flags, channel enables
//   iq_re_o, cpu_re_o            : FIFO read enables (1-cycle read latency)
//   cpu_data_i, cpu_wc_i         : CPU FIFO read data and wrapping committed-word count
//   re_i                         : FTDI read request, sampled only while idle
//   data_o, available_o, src_o   : registered output word, packet ready/in progress, source id
module ft_tx_arbiter #(
  parameter int FT_DATA_WIDTH    = 32,
  parameter int IQ_PAIR_WIDTH    = 24,
  parameter int QSTART_BIT_INDEX = 16,
  parameter int N_IQ             = 2,
  parameter int PKT_WORDS        = 1024,
  parameter int WC_WIDTH         = 8,
  parameter int HDR_EN           = 1,
  parameter int CPU_STARVE_LIMIT = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n,
  input  logic [N_IQ*IQ_PAIR_WIDTH-1:0] iq_data_i,
  input  logic [N_IQ-1:0]               iq_enough_i,
  input  logic [N_IQ-1:0]               iq_mask_i,
  output logic [N_IQ-1:0]               iq_re_o,
  input  logic [FT_DATA_WIDTH-1:0]      cpu_data_i,
  input  logic [WC_WIDTH-1:0]           cpu_wc_i,
  output logic                          cpu_re_o,
  input  logic                          re_i,
  output logic [FT_DATA_WIDTH-1:0]      data_o,
  output logic                          available_o,
  output logic [3:0]                    src_o
);
  localparam int LW = 17;
  localparam int HW = IQ_PAIR_WIDTH / 2;
  typedef enum logic [1:0] {IDLE, HDR, STREAM} state_t;
  state_t state_q, state_d;
  logic [WC_WIDTH-1:0] cpu_done_q, cpu_done_d, cpu_len;
  logic [3:0] rr_q, rr_d, sel_q, sel_d, src_q, src_d, iq_pick;
  logic [15:0] starve_q, starve_d;
  logic [LW-1:0] rem_q, rem_d, len_q, len_d, len_m1;
  logic vld_q, vld_d, avail_q, avail_d, cpu_re_q, cpu_re_d;
  logic [N_IQ-1:0] iq_re_q, iq_re_d, elig;
  logic [FT_DATA_WIDTH-1:0] data_q, data_d, iq_word, hdr;
  logic [IQ_PAIR_WIDTH-1:0] iq_w;
  logic cpu_pend, iq_any, starved, take_iq, cand;
  always_comb begin
    int idx;
    idx = 0;
    cpu_pend = cpu_wc_i != cpu_done_q;
    cpu_len = cpu_wc_i - cpu_done_q;
    elig = iq_enough_i & iq_mask_i;
    iq_any = |elig;
    starved = CPU_STARVE_LIMIT != 0 && starve_q >= 16'(CPU_STARVE_LIMIT);
    take_iq = iq_any && (!cpu_pend || starved);
    cand = cpu_pend || iq_any;
    // descending search so the closest eligible channel after rr_q wins
    iq_pick = '0;
    for (int j = N_IQ - 1; j >= 0; j--) begin
      idx = int'(rr_q) + j;
      if (idx >= N_IQ) idx = idx - N_IQ;
      if (elig[idx]) iq_pick = 4'(idx);
    end
    iq_w = '0;
    for (int k = 0; k < N_IQ; k++)
      if (sel_q == 4'(k + 1)) iq_w = iq_data_i[k*IQ_PAIR_WIDTH +: IQ_PAIR_WIDTH];
    iq_word = '0;
    iq_word[HW-1:0] = iq_w[HW-1:0];
    iq_word[QSTART_BIT_INDEX +: HW] = iq_w[IQ_PAIR_WIDTH-1:HW];
    len_m1 = len_q - 1'b1;
    hdr = '0;
    hdr[31:0] = {8'hA5, sel_q, 4'h0, len_m1[15:0]};
    state_d = state_q;
    cpu_done_d = cpu_done_q;
    rr_d = rr_q;
    sel_d = sel_q;
    src_d = src_q;
    starve_d = starve_q;
    len_d = len_q;
    avail_d = avail_q;
    rem_d = rem_q != '0 ? rem_q - 1'b1 : rem_q;
    // read data is valid the cycle after any read enable
    vld_d = cpu_re_q || (|iq_re_q);
    data_d = vld_q ? (sel_q == '0 ? cpu_data_i : iq_word) : data_q;
    case (state_q)
      IDLE: begin
        avail_d = cand;
        if (re_i && cand) begin
          sel_d = take_iq ? iq_pick + 4'd1 : 4'd0;
          src_d = sel_d;
          len_d = take_iq ? LW'(PKT_WORDS) : LW'(cpu_len);
          rem_d = len_d;
          rr_d = take_iq ? (iq_pick + 4'd1 == 4'(N_IQ) ? 4'd0 : iq_pick + 4'd1) : rr_q;
          cpu_done_d = take_iq ? cpu_done_q : cpu_wc_i;
          starve_d = take_iq ? '0 : (starve_q == '1 ? starve_q : starve_q + 1'b1);
          state_d = HDR_EN != 0 ? HDR : STREAM;
        end
      end
      HDR: begin
        data_d = hdr;
        state_d = STREAM;
      end
      default: begin
        // last payload word registers once no read is outstanding
        if (vld_q && !(cpu_re_q || (|iq_re_q))) begin
          avail_d = 1'b0;
          src_d = '0;
          state_d = IDLE;
        end
      end
    endcase
    cpu_re_d = rem_d != '0 && sel_d == '0;
    for (int k = 0; k < N_IQ; k++) iq_re_d[k] = rem_d != '0 && sel_d == 4'(k + 1);
  end
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cpu_done_q <= '0;
      rr_q <= '0;
      sel_q <= '0;
      src_q <= '0;
      starve_q <= '0;
      len_q <= '0;
      rem_q <= '0;
      vld_q <= 1'b0;
      avail_q <= 1'b0;
      cpu_re_q <= 1'b0;
      iq_re_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      cpu_done_q <= cpu_done_d;
      rr_q <= rr_d;
      sel_q <= sel_d;
      src_q <= src_d;
      starve_q <= starve_d;
      len_q <= len_d;
      rem_q <= rem_d;
      vld_q <= vld_d;
      avail_q <= avail_d;
      cpu_re_q <= cpu_re_d;
      iq_re_q <= iq_re_d;
      data_q <= data_d;
    end
  end
  assign data_o = data_q;
  assign available_o = avail_q;
  assign src_o = src_q;
  assign cpu_re_o = cpu_re_q;
  assign iq_re_o = iq_re_q;
endmodule
